// File: rtl/fnd_scan_ctrl.sv
// Memory-mapped seven-segment scan controller for 1..8 common-anode digits.
// Decimal values go through a 32-step shift-add-3 engine. The display
// latch changes only when a conversion finishes or on a hex reload.
// Bus handshake: there is no valid/ready pair. A register write is
// accepted on any rising edge where cs & wr = 1. rdata is a purely
// combinational decode of addr[3:2] and does not depend on cs.
module fnd_scan_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int CLK_HZ      = 100_000_000,
   parameter int SCAN_HZ     = 1000,
   parameter int BLINK_TICKS = 250
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cs,
   input  logic                  wr,
   input  logic [31:0]           addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   output logic [NUM_DIGITS-1:0] fnd_com,
   output logic [7:0]            fnd_font
);

   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW  = $clog2(BLINK_TICKS + 1);
   localparam int DW  = 4 * NUM_DIGITS;

   typedef enum logic {CONV_IDLE, CONV_RUN} conv_state_t;

   conv_state_t           state_q, state_d;
   logic [3:0]            fcr_q, fcr_d;
   logic [31:0]           fdr_q, fdr_d;
   logic [NUM_DIGITS-1:0] fdp_q, fdp_d;
   logic [DW-1:0]         disp_q, disp_d;
   logic [31:0]           sh_q, sh_d;
   logic [DW-1:0]         bcd_q, bcd_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [PW-1:0]         presc_q, presc_d;
   logic [2:0]            idx_q, idx_d;
   logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
   logic                  phase_q, phase_d;

   logic                  wr_fcr, wr_fdr, wr_fdp, reload, hex_new;
   logic                  busy, conv_last, tick;
   logic [DW+31:0]        step_val;
   logic [NUM_DIGITS-1:0] zero_from;
   logic [3:0]            cur_dig;
   logic                  cur_dp, cur_blank;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

   // One double-dabble step: adjust every BCD digit >= 5, then shift left.
   // Only the lowest NUM_DIGITS digits are kept, which gives value mod 10^N
   // because adjustments never carry downward.
   function automatic logic [DW+31:0] dd_step(input logic [DW-1:0] b,
                                              input logic [31:0] s);
      logic [DW-1:0] a;
      a = b;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end
      return {a[DW-2:0], s, 1'b0};
   endfunction

   function automatic logic [6:0] seg_font(input logic [3:0] d);
      case (d)
         4'h0: return 7'h40;  4'h1: return 7'h79;
         4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;
         4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;
         4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;
         4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   // Conversion state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= CONV_IDLE;
      else     state_q <= state_d;
   end

   // Conversion next state: a reload always wins over completion
   always_comb begin
      state_d = state_q;
      if (reload)         state_d = hex_new ? CONV_IDLE : CONV_RUN;
      else if (conv_last) state_d = CONV_IDLE;
   end

   // Conversion outputs: BUSY flag and final-step strobe
   always_comb begin
      busy      = (state_q == CONV_RUN);
      conv_last = busy && !reload && (cnt_q == 5'd31);
   end

   // Register writes and display/converter datapath next values
   always_comb begin
      wr_fcr   = cs && wr && (addr[3:2] == 2'd0);
      wr_fdr   = cs && wr && (addr[3:2] == 2'd1);
      wr_fdp   = cs && wr && (addr[3:2] == 2'd2);
      reload   = wr_fcr || wr_fdr;
      fcr_d    = wr_fcr ? wdata[3:0] : fcr_q;
      fdr_d    = wr_fdr ? wdata : fdr_q;
      fdp_d    = wr_fdp ? wdata[NUM_DIGITS-1:0] : fdp_q;
      hex_new  = fcr_d[1];
      step_val = dd_step(bcd_q, sh_q);
      disp_d   = disp_q;
      sh_d     = sh_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      if (reload) begin
         if (hex_new) begin
            disp_d = fdr_d[DW-1:0];
         end else begin
            sh_d  = fdr_d;
            bcd_d = '0;
            cnt_d = 5'd0;
         end
      end else if (busy) begin
         bcd_d = step_val[DW+31:32];
         sh_d  = step_val[31:0];
         cnt_d = cnt_q + 5'd1;
         if (conv_last) disp_d = step_val[DW+31:32];
      end
   end

   // Scan prescaler, digit index and blink phase next values
   always_comb begin
      tick        = (presc_q == PW'(DIV - 1));
      presc_d     = tick ? '0 : presc_q + PW'(1);
      idx_d       = idx_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (tick) begin
         idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
         if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
         end
      end
   end

   // All datapath and scan state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fcr_q       <= '0;
         fdr_q       <= '0;
         fdp_q       <= '0;
         disp_q      <= '0;
         sh_q        <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         presc_q     <= '0;
         idx_q       <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else begin
         fcr_q       <= fcr_d;
         fdr_q       <= fdr_d;
         fdp_q       <= fdp_d;
         disp_q      <= disp_d;
         sh_q        <= sh_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         presc_q     <= presc_d;
         idx_q       <= idx_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
      end
   end

   // zero_from[i] = digits i..NUM_DIGITS-1 are all zero
   always_comb begin
      zero_from = '0;
      zero_from[NUM_DIGITS-1] = (disp_q[DW-1 -: 4] == 4'd0);
      for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
         zero_from[i] = zero_from[i+1] && (disp_q[4*i +: 4] == 4'd0);
      end
   end

   // Digit drive and segment font for the current scan index
   always_comb begin
      cur_dig   = 4'd0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == 3'(i)) begin
            cur_dig   = disp_q[4*i +: 4];
            cur_dp    = fdp_q[i];
            cur_blank = fcr_q[2] && (i != 0) && zero_from[i];
         end
      end
      fnd_font = {~cur_dp, cur_blank ? 7'h7F : seg_font(cur_dig)};
      fnd_com  = '1;
      if (fcr_q[0] && !(fcr_q[3] && phase_q))
         fnd_com = ~(NUM_DIGITS'(1) << idx_q);
   end

   // Register read-back
   always_comb begin
      rdata = '0;
      case (addr[3:2])
         2'd0: rdata[3:0] = fcr_q;
         2'd1: rdata = fdr_q;
         2'd2: rdata[NUM_DIGITS-1:0] = fdp_q;
         default: begin
            rdata[0]    = busy;
            rdata[10:8] = idx_q;
         end
      endcase
   end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl with a 4-digit, DIV=10, BLINK_TICKS=2 build.
module tb_fnd_scan_ctrl;

   localparam int N   = 4;
   localparam int DIV = 10;
   localparam int BT  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          cs, wr;
   logic [31:0]   addr, wdata, rdata;
   logic [N-1:0]  fnd_com;
   logic [7:0]    fnd_font;

   fnd_scan_ctrl #(.NUM_DIGITS(N), .CLK_HZ(1000), .SCAN_HZ(100), .BLINK_TICKS(BT)) dut (
      .clk(clk), .rst(rst), .cs(cs), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata), .fnd_com(fnd_com), .fnd_font(fnd_font)
   );

   // Clock
   always #5 clk = ~clk;

   int err_cnt = 0;
   int chk_cnt = 0;

   logic [7:0] font_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Reference model: edge count since reset release, registers, shown digits
   int unsigned n;
   logic [3:0]  m_fcr;
   logic [31:0] m_fdr;
   logic [3:0]  m_fdp;
   logic [15:0] m_disp;
   bit          m_pend;
   int unsigned m_end;
   logic [15:0] m_pend_val;
   logic [7:0]  cap [N];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=%0h exp=%0h (edge %0d)", tag, got, exp, n);
      end
   endtask

   function automatic void model_reset();
      n = 0; m_fcr = '0; m_fdr = '0; m_fdp = '0; m_disp = '0;
      m_pend = 0; m_end = 0; m_pend_val = '0;
   endfunction

   // Lowest four decimal digits of v as packed BCD
   function automatic logic [15:0] to_bcd(input logic [31:0] v);
      int unsigned r, p;
      logic [15:0] o;
      r = v % 10000;
      p = 1;
      o = '0;
      for (int i = 0; i < N; i++) begin
         o[4*i +: 4] = 4'((r / p) % 10);
         p = p * 10;
      end
      return o;
   endfunction

   function automatic int unsigned m_idx();
      return (n / DIV) % N;
   endfunction

   function automatic logic [3:0] exp_com();
      int unsigned ph;
      ph = (n / (DIV * BT)) % 2;
      if (m_fcr[0] && !(m_fcr[3] && ph == 1)) return ~(4'b0001 << m_idx());
      return 4'hF;
   endfunction

   function automatic logic [7:0] exp_font();
      int unsigned i;
      logic [7:0] f;
      i = m_idx();
      f = font_tab[m_disp[4*i +: 4]];
      if (m_fcr[2] && i > 0 && (m_disp >> (4*i)) == 16'd0) f = 8'hFF;
      if (m_fdp[i]) f[7] = 1'b0;
      return f;
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [1:0] sel);
      case (sel)
         2'd0: return {28'd0, m_fcr};
         2'd1: return m_fdr;
         2'd2: return {28'd0, m_fdp};
         default: return {21'd0, 3'(m_idx()), 7'd0, 1'(m_pend)};
      endcase
   endfunction

   // Applies the bus transaction present at this edge to the model
   function automatic void model_edge();
      bit do_wr, reload;
      do_wr  = cs && wr;
      reload = do_wr && (addr[3:2] == 2'd0 || addr[3:2] == 2'd1);
      if (do_wr) begin
         case (addr[3:2])
            2'd0: m_fcr = wdata[3:0];
            2'd1: m_fdr = wdata;
            2'd2: m_fdp = wdata[3:0];
            default: ;
         endcase
      end
      if (reload) begin
         if (m_fcr[1]) begin
            m_disp = m_fdr[15:0];
            m_pend = 0;
         end else begin
            m_pend     = 1;
            m_end      = n + 32;
            m_pend_val = to_bcd(m_fdr);
         end
      end else if (m_pend && n == m_end) begin
         m_disp = m_pend_val;
         m_pend = 0;
      end
   endfunction

   // Driver: set bus for the coming edge, then check combinational read data
   task automatic drive(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
      cs = c; wr = w; addr = a; wdata = d;
      #1;
      check_val("rdata", rdata, exp_rdata(addr[3:2]));
   endtask

   // One clock edge, model update, output checks
   task automatic step();
      @(posedge clk);
      n++;
      model_edge();
      #1;
      check_val("fnd_com", {28'd0, fnd_com}, {28'd0, exp_com()});
      check_val("fnd_font", {24'd0, fnd_font}, {24'd0, exp_font()});
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         drive(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
         step();
      end
   endtask

   task automatic wr_reg(input logic [1:0] sel, input logic [31:0] d);
      drive(1'b1, 1'b1, {28'd0, sel, 2'b00}, d);
      step();
   endtask

   task automatic capture(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         drive(1'b0, 1'b0, 32'h0, 32'h0);
         step();
         cap[m_idx()] = fnd_font;
      end
   endtask

   // Counts BUSY cycles over a bounded window
   task automatic count_busy(output int cnt);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         drive(1'b0, 1'b0, 32'hC, 32'h0);
         if (rdata[0]) cnt++;
         step();
      end
   endtask

   initial begin
      int bc, act;
      logic [1:0] sel;
      logic [31:0] d;

      // Reset
      rst = 1'b1; cs = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
      model_reset();
      #20 rst = 1'b0;
      #1;
      check_val("rst_com", {28'd0, fnd_com}, 32'hF);
      check_val("rst_font", {24'd0, fnd_font}, 32'hC0);
      for (int s = 0; s < 4; s++) begin
         drive(1'b0, 1'b0, 32'(s) << 2, 32'h0);
         check_val("rst_read", rdata, 32'h0);
         step();
      end

      // Enable scanning
      wr_reg(2'd0, 32'h1);
      idle(50);

      // Decimal conversion 1234
      wr_reg(2'd1, 32'd1234);
      count_busy(bc);
      check_val("busy_len_1234", 32'(bc), 32'd32);
      capture(40);
      check_val("dec_d0", {24'd0, cap[0]}, 32'h99);
      check_val("dec_d1", {24'd0, cap[1]}, 32'hB0);
      check_val("dec_d2", {24'd0, cap[2]}, 32'hA4);
      check_val("dec_d3", {24'd0, cap[3]}, 32'hF9);

      // Value wraps mod 10^4
      wr_reg(2'd1, 32'd98765);
      idle(33);
      capture(40);
      check_val("mod_d3", {24'd0, cap[3]}, 32'h80);
      check_val("mod_d0", {24'd0, cap[0]}, 32'h92);

      // Restart during BUSY
      wr_reg(2'd1, 32'd1234);
      idle(4);
      wr_reg(2'd1, 32'd42);
      count_busy(bc);
      check_val("busy_len_restart", 32'(bc), 32'd32);
      capture(40);
      check_val("rst42_d0", {24'd0, cap[0]}, 32'hA4);
      check_val("rst42_d1", {24'd0, cap[1]}, 32'h99);

      // Hex mode
      wr_reg(2'd0, 32'h3);
      drive(1'b0, 1'b0, 32'hC, 32'h0);
      check_val("hex_busy", {31'd0, rdata[0]}, 32'd0);
      capture(40);
      check_val("hex_d0", {24'd0, cap[0]}, 32'h88);
      check_val("hex_d1", {24'd0, cap[1]}, 32'hA4);
      check_val("hex_d2", {24'd0, cap[2]}, 32'hC0);
      check_val("hex_d3", {24'd0, cap[3]}, 32'hC0);

      // Leading-zero blanking with decimal points
      wr_reg(2'd0, 32'h5);
      wr_reg(2'd1, 32'd7);
      wr_reg(2'd2, 32'h4);
      idle(33);
      capture(40);
      check_val("lzb_d0", {24'd0, cap[0]}, 32'hF8);
      check_val("lzb_d1", {24'd0, cap[1]}, 32'hFF);
      check_val("lzb_d2", {24'd0, cap[2]}, 32'h7F);
      check_val("lzb_d3", {24'd0, cap[3]}, 32'hFF);
      wr_reg(2'd1, 32'd0);
      idle(33);
      capture(40);
      check_val("lzb_zero_d0", {24'd0, cap[0]}, 32'hC0);

      // Blink: any 80-cycle window is half active
      wr_reg(2'd0, 32'h9);
      act = 0;
      for (int i = 0; i < 80; i++) begin
         drive(1'b0, 1'b0, 32'h0, 32'h0);
         step();
         if (fnd_com != 4'hF) act++;
      end
      check_val("blink_active", 32'(act), 32'd40);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            sel = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
               0: d = $urandom;
               1: d = $urandom_range(0, 99999);
               default: d = $urandom_range(0, 15);
            endcase
            if (sel == 2'd0) d[0] = ($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 7) != 0), 1'b1,
                  {$urandom} & 32'hFFFF_FFF3 | {28'd0, sel, 2'b00}, d);
         end else begin
            drive(1'($urandom_range(0, 1)), 1'b0, $urandom, $urandom);
         end
         step();
      end

      // Reset in the middle of a conversion
      wr_reg(2'd0, 32'h1);
      wr_reg(2'd1, 32'd5555);
      idle(10);
      cs = 1'b0; wr = 1'b0; addr = 32'hC;
      #2 rst = 1'b1;
      #1;
      check_val("midrst_com", {28'd0, fnd_com}, 32'hF);
      check_val("midrst_font", {24'd0, fnd_font}, 32'hC0);
      check_val("midrst_fsr", rdata, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      idle(60);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
